// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
package regfile_pkg;
  localparam int DATA_W           = 32;
  localparam int ADDR_W           = 4;
  localparam int NUM_REGS         = 16;
  localparam int PC_REG           = 15;
  localparam int DEF_STARVE_LIMIT = 3;

  // Grant vector bit positions
  localparam int GNT_LD  = 0;
  localparam int GNT_ALU = 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_prio_arbiter.sv
// Two-way arbiter: load beats ALU unless the ALU has been stalled STARVE_LIMIT cycles in a row.
module wb_prio_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ld_req,
  input  logic       i_alu_req,
  input  logic       i_alu_valid,
  output logic [1:0] o_grant,
  output logic       o_ld_ready,
  output logic       o_alu_ready
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_starved;

  assign w_starved = (r_stall_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    o_grant = '0;
    if (w_starved && i_alu_req)
      o_grant[GNT_ALU] = 1'b1;
    else if (i_ld_req)
      o_grant[GNT_LD] = 1'b1;
    else if (i_alu_req)
      o_grant[GNT_ALU] = 1'b1;
  end

  assign o_ld_ready  = o_grant[GNT_LD];
  assign o_alu_ready = o_grant[GNT_ALU];

  // Saturates at the limit so an ALU blocked for other reasons keeps its priority claim.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (!i_alu_valid || o_grant[GNT_ALU])
      r_stall_cnt <= '0;
    else if (!w_starved)
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end
endmodule

// File: rtl/regfile_writeback.sv
// Write-side controller: arbitrates ALU/load results onto the general and r15 write ports,
// keeps the busy scoreboard and drives a one-cycle forwarding copy of the write in flight.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                pc_valid,
  input  logic [DATA_W-1:0]   pc_data,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                wEn1,
  output logic [ADDR_W-1:0]   wA1,
  output logic [DATA_W-1:0]   wD1,
  output logic                wEn15,
  output logic [DATA_W-1:0]   wDr15,
  output logic                fwd_valid,
  output logic [ADDR_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0]   fwd_data
);
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

  logic [1:0]          w_grant;
  logic                w_ld_req, w_alu_req;
  wb_req_t             w_sel;
  logic                w_sel_pc;
  logic [NUM_REGS-1:0] w_set, w_clr;

  logic                r_wen1, r_wen15, r_fwd_valid;
  logic [ADDR_W-1:0]   r_wa1, r_fwd_rd;
  logic [DATA_W-1:0]   r_wd1, r_wdr15, r_fwd_data;
  logic [NUM_REGS-1:0] r_busy;

  // A PC update owns the r15 port, so data-path r15 results wait; readies stay low in reset.
  assign w_ld_req  = rst_n & ld_valid  & ~(pc_valid & (ld_rd  == PC_A));
  assign w_alu_req = rst_n & alu_valid & ~(pc_valid & (alu_rd == PC_A));

  wb_prio_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ld_req   (w_ld_req),
    .i_alu_req  (w_alu_req),
    .i_alu_valid(alu_valid),
    .o_grant    (w_grant),
    .o_ld_ready (ld_ready),
    .o_alu_ready(alu_ready)
  );

  always_comb begin
    w_sel.valid = |w_grant;
    w_sel.rd    = w_grant[GNT_LD] ? ld_rd   : alu_rd;
    w_sel.data  = w_grant[GNT_LD] ? ld_data : alu_data;
    w_sel_pc    = w_sel.valid && (w_sel.rd == PC_A);
    w_set       = '0;
    w_clr       = '0;
    if (iss_valid)   w_set[iss_rd]   = 1'b1;
    if (w_sel.valid) w_clr[w_sel.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen1      <= 1'b0;
      r_wa1       <= '0;
      r_wd1       <= '0;
      r_wen15     <= 1'b0;
      r_wdr15     <= '0;
      r_fwd_valid <= 1'b0;
      r_fwd_rd    <= '0;
      r_fwd_data  <= '0;
      r_busy      <= '0;
    end else begin
      r_busy      <= (r_busy & ~w_clr) | w_set;
      r_wen1      <= w_sel.valid & ~w_sel_pc;
      r_wen15     <= w_sel_pc | pc_valid;
      r_fwd_valid <= w_sel.valid | pc_valid;
      if (w_sel.valid && !w_sel_pc) begin
        r_wa1 <= w_sel.rd;
        r_wd1 <= w_sel.data;
      end
      if (w_sel_pc)
        r_wdr15 <= w_sel.data;
      else if (pc_valid)
        r_wdr15 <= pc_data;
      // Forwarding prefers the general-port write when both ports fire.
      if (w_sel.valid) begin
        r_fwd_rd   <= w_sel.rd;
        r_fwd_data <= w_sel.data;
      end else if (pc_valid) begin
        r_fwd_rd   <= PC_A;
        r_fwd_data <= pc_data;
      end
    end
  end

  assign wEn1      = r_wen1;
  assign wA1       = r_wa1;
  assign wD1       = r_wd1;
  assign wEn15     = r_wen15;
  assign wDr15     = r_wdr15;
  assign fwd_valid = r_fwd_valid;
  assign fwd_rd    = r_fwd_rd;
  assign fwd_data  = r_fwd_data;
  assign busy      = r_busy;
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the 16×32 register file: collects results from the ALU and the load unit over valid/ready handshakes, arbitrates them onto the register file's single general write port and its dedicated r15 (PC) port, and tracks pending destinations in a busy scoreboard. Sits between the execute/memory stages and the register file. Also drives a one-cycle forwarding bus so readers never see a stale value while a write is in flight.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 4, register address width
- `STARVE_LIMIT`, 3, consecutive stalled ALU cycles before the ALU gets priority for one grant

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `alu_valid` / `alu_ready`  in / out  1  ALU result handshake
- `alu_rd`, `alu_data`  in  ADDR_W, DATA_W  ALU destination and value
- `ld_valid` / `ld_ready`  in / out  1  load result handshake
- `ld_rd`, `ld_data`  in  ADDR_W, DATA_W  load destination and value
- `pc_valid`  in  1  PC update request (branch/sequential), never back-pressured
- `pc_data`  in  DATA_W  new r15 value
- `iss_valid`, `iss_rd`  in  1, ADDR_W  issue stage reserves a destination
- `busy`  out  16  scoreboard, bit i set = write to ri pending
- `wEn1`, `wA1`, `wD1`  out  1, ADDR_W, DATA_W  general write port
- `wEn15`, `wDr15`  out  1, DATA_W  r15 write port
- `fwd_valid`, `fwd_rd`, `fwd_data`  out  1, ADDR_W, DATA_W  copy of the write being presented this cycle

## Operation
- Transfer on a source = valid & ready at a rising edge.
- Default priority: load over ALU. ALU stall counter increments on each cycle with `alu_valid & ~alu_ready`, clears on an ALU transfer or when `alu_valid` is low; when counter == STARVE_LIMIT the ALU has priority for that cycle.
- At most one data-path result is accepted per cycle; the loser's ready is low.
- Destination r15 (rd == 15) from ALU or load is routed to `wEn15/wDr15`, not `wEn1`. If `pc_valid` is high, every data-path source with rd == 15 has ready forced low; data-path sources with rd != 15 are unaffected. `pc_valid` always produces `wEn15` with `wDr15 = pc_data`.
- Accepted result registered into `wEn1/wA1/wD1` (or `wEn15/wDr15`) and mirrored on `fwd_*` (`fwd_rd` = 15 for r15 writes, including PC updates; PC update wins `fwd_*` if a data-path non-r15 write coexists? No: `fwd_*` shows the `wEn1` write when present, else the r15 write).
- Scoreboard: `iss_valid` sets `busy[iss_rd]`; a transfer clears `busy[rd]`; same-edge set and clear of the same bit → set wins. PC updates do not touch `busy`.
- Results for a register not marked busy are still written (no filtering).
- Reset: `alu_ready`, `ld_ready`, `wEn1`, `wEn15`, `fwd_valid` = 0; `wA1`, `wD1`, `wDr15`, `fwd_rd`, `fwd_data` = 0; `busy` = 0; stall counter = 0. Reset mid-transfer drops the in-flight write and all reservations.

## Timing
- Ready signals combinational from valids, rd fields, `pc_valid`, stall counter (no dependency on ready inputs → no loops).
- Transfer at edge N → `wEn1`/`wEn15` high during cycle N+1 → register file updated at edge N+2. `fwd_*` valid during cycle N+1, covering the stale-read window.
- `busy[rd]` clears at edge N (same edge as the transfer); `fwd_*` covers readers during N+1.
- Write outputs are single-cycle pulses; back-to-back transfers give continuous `wEn1`.
- Throughput: one general write plus one r15 write per cycle.

## Structure
- Shared package `regfile_pkg`: `DATA_W`, `ADDR_W`, `PC_REG` = 15, `NUM_REGS` = 16, default `STARVE_LIMIT`, a `wb_req_t` struct {valid, rd, data}.
- Sub-module `wb_prio_arbiter`: two requesters, fixed priority with starvation counter, outputs grant one-hot and the ready signals; scoreboard and output registers stay in the top.

## Test plan
- Reset: hold `rst_n`=0 two cycles with all valids high → all outputs 0, `busy`=0; release → first transfers appear one cycle later.
- ALU only: iss r3, then `alu_rd`=3, `alu_data`=0xDEADBEEF → `busy[3]` 1 then 0 at transfer edge; next cycle `wEn1`=1, `wA1`=3, `fwd_data`=0xDEADBEEF.
- Contention: load and ALU valid continuously (rd 1, 2) → load wins 3 cycles, ALU wins the 4th, pattern repeats; `alu_ready` high only every 4th cycle.
- r15 conflict: `pc_valid`=1, `pc_data`=0x100 with `ld_rd`=15 valid → `ld_ready`=0, `wEn15`=1 with 0x100; next cycle `pc_valid`=0 → load accepted, `wDr15`=load data, `wEn1`=0.
- Scoreboard race: `iss_rd`=5 and ALU transfer to r5 same edge → `busy[5]` stays 1.
- Mid-operation reset: transfer at edge N, `rst_n`=0 sampled at edge N+1 → `wEn1` low after that edge, `busy`=0.
